// File: rtl/fp_mul_sched.sv
// Round-robin scheduler sharing one pipelined fp_mul among N_REQ requesters.
// Each result returns to its issuing requester MUL_LAT+1 cycles after acceptance.
module fp_mul_sched #(
    parameter int N_REQ   = 4,
    parameter int I_EXP   = 5,
    parameter int I_MNT   = 10,
    parameter int I_DATA  = I_EXP + I_MNT + 1,
    parameter int MUL_LAT = 3,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ*I_DATA-1:0]       req_a,
    input  logic [N_REQ*I_DATA-1:0]       req_b,
    output logic [I_DATA-1:0]             mul_a,
    output logic [I_DATA-1:0]             mul_b,
    input  logic [I_DATA-1:0]             mul_result,
    output logic [N_REQ-1:0]              rsp_valid,
    output logic [I_DATA-1:0]             rsp_data,
    output logic [$clog2(MUL_LAT+2)-1:0]  inflight,
    output logic                          idle
);

    logic [ID_W-1:0]    rr_ptr;
    logic               gnt_any;
    logic [ID_W-1:0]    gnt_id;
    logic [MUL_LAT:0]   tag_v;
    logic [ID_W-1:0]    tag_id [MUL_LAT];

    // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        if (!reset && en) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!gnt_any && req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
                    gnt_any = 1'b1;
                    gnt_id  = ID_W'((int'(rr_ptr) + k) % N_REQ);
                end
            end
        end
    end

    assign req_ready = gnt_any ? (N_REQ'(1) << gnt_id) : '0;
    assign mul_a     = gnt_any ? req_a[gnt_id*I_DATA +: I_DATA] : '0;
    assign mul_b     = gnt_any ? req_b[gnt_id*I_DATA +: I_DATA] : '0;
    assign idle      = (inflight == '0) && !gnt_any;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            tag_v     <= '0;
            for (int s = 0; s < MUL_LAT; s++) tag_id[s] <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            inflight  <= '0;
        end else begin
            if (gnt_any)
                rr_ptr <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;

            tag_v     <= {tag_v[MUL_LAT-1:0], gnt_any};
            tag_id[0] <= gnt_id;
            for (int s = 1; s < MUL_LAT; s++) tag_id[s] <= tag_id[s-1];

            // Stage MUL_LAT-1 lines up with the multiplier output for its op.
            if (tag_v[MUL_LAT-1]) begin
                rsp_valid <= N_REQ'(1) << tag_id[MUL_LAT-1];
                rsp_data  <= mul_result;
            end else begin
                rsp_valid <= '0;
            end

            // The last valid stage is high exactly while a response pulse is out.
            case ({gnt_any, tag_v[MUL_LAT]})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_sched.sv
// Bench for fp_mul_sched: behavioural fp_mul pipeline, reference arbiter and
// response scoreboard checked every cycle on the falling edge.
module tb_fp_mul_sched;

    localparam int N_REQ   = 4;
    localparam int I_DATA  = 16;
    localparam int MUL_LAT = 3;
    localparam int CNT_W   = $clog2(MUL_LAT + 2);

    typedef struct {
        int                id;
        logic [I_DATA-1:0] data;
        int                due;
    } sb_t;

    logic                      clk = 1'b0;
    logic                      reset = 1'b0;
    logic                      en = 1'b0;
    logic [N_REQ-1:0]          req_valid = '0;
    logic [N_REQ-1:0]          req_ready;
    logic [N_REQ*I_DATA-1:0]   req_a;
    logic [N_REQ*I_DATA-1:0]   req_b;
    logic [I_DATA-1:0]         mul_a;
    logic [I_DATA-1:0]         mul_b;
    logic [I_DATA-1:0]         mul_result;
    logic [N_REQ-1:0]          rsp_valid;
    logic [I_DATA-1:0]         rsp_data;
    logic [CNT_W-1:0]          inflight;
    logic                      idle;

    logic [I_DATA-1:0]         a_drv   [N_REQ];
    logic [I_DATA-1:0]         b_drv   [N_REQ];
    logic [I_DATA-1:0]         exp_drv [N_REQ];
    logic [I_DATA-1:0]         mp      [MUL_LAT];
    logic [N_REQ-1:0]          accepted = '0;
    sb_t                       sb_q [$];
    int                        cyc = 0;
    int                        m_ptr = 0;
    int                        n_checks = 0;
    int                        n_errors = 0;

    fp_mul_sched #(
        .N_REQ   (N_REQ),
        .I_EXP   (5),
        .I_MNT   (10),
        .I_DATA  (I_DATA),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .inflight   (inflight),
        .idle       (idle)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Half-precision multiply for normal operands, truncating.
    function automatic logic [I_DATA-1:0] fpmul(input logic [I_DATA-1:0] a,
                                                input logic [I_DATA-1:0] b);
        logic [21:0] p;
        int          e;
        logic [9:0]  m;
        p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
        e = int'(a[14:10]) + int'(b[14:10]) - 15;
        if (p[21]) begin
            m = p[20:11];
            e = e + 1;
        end else begin
            m = p[19:10];
        end
        return {a[15] ^ b[15], e[4:0], m};
    endfunction

    function automatic logic [I_DATA-1:0] rnd_fp();
        return {1'($urandom_range(0, 1)), 5'($urandom_range(10, 20)), 10'($urandom)};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < MUL_LAT; s++) mp[s] <= '0;
        end else begin
            mp[0] <= fpmul(mul_a, mul_b);
            for (int s = 1; s < MUL_LAT; s++) mp[s] <= mp[s-1];
        end
    end
    assign mul_result = mp[MUL_LAT-1];

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_a[i*I_DATA +: I_DATA] = a_drv[i];
            req_b[i*I_DATA +: I_DATA] = b_drv[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [I_DATA-1:0] a,
                           input logic [I_DATA-1:0] b, input logic [I_DATA-1:0] x);
        a_drv[i]   = a;
        b_drv[i]   = b;
        exp_drv[i] = x;
    endtask

    always @(negedge clk) begin : monitor
        logic             exp_any;
        int               exp_g;
        logic [N_REQ-1:0] exp_rdy;
        sb_t              ent;
        exp_any = 1'b0;
        exp_g   = 0;
        if (reset) begin
            sb_q.delete();
            m_ptr = 0;
        end else if (en) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!exp_any && req_valid[(m_ptr + k) % N_REQ]) begin
                    exp_any = 1'b1;
                    exp_g   = (m_ptr + k) % N_REQ;
                end
            end
        end
        exp_rdy = exp_any ? (N_REQ'(1) << exp_g) : '0;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("mul_a", 32'(mul_a), exp_any ? 32'(a_drv[exp_g]) : 32'd0);
        check("mul_b", 32'(mul_b), exp_any ? 32'(b_drv[exp_g]) : 32'd0);
        check("inflight", 32'(inflight), 32'(sb_q.size()));
        check("idle", 32'(idle), 32'(sb_q.size() == 0 && !exp_any));
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            ent = sb_q.pop_front();
            check("rsp_valid", 32'(rsp_valid), 32'(N_REQ'(1) << ent.id));
            check("rsp_data", 32'(rsp_data), 32'(ent.data));
        end else begin
            check("rsp_quiet", 32'(rsp_valid), 32'd0);
        end
        accepted = exp_rdy;
        if (exp_any) begin
            ent.id   = exp_g;
            ent.data = exp_drv[exp_g];
            ent.due  = cyc + MUL_LAT + 1;
            sb_q.push_back(ent);
            m_ptr = (exp_g + 1) % N_REQ;
        end
    end

    initial begin
        logic [I_DATA-1:0] ra;
        logic [I_DATA-1:0] rb;
        for (int i = 0; i < N_REQ; i++) set_req(i, '0, '0, '0);
        #2 reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        en    = 1'b1;
        repeat (4) step();

        // single op: 1.0 * 2.0 from requester 0
        set_req(0, 16'h3C00, 16'h4000, 16'h4000);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        repeat (8) step();

        // fresh reset, then all four continuously valid for eight cycles
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        set_req(0, 16'h3C00, 16'h4000, 16'h4000);
        set_req(1, 16'h3E00, 16'h3E00, 16'h4080);
        set_req(2, 16'h4200, 16'h4000, 16'h4600);
        set_req(3, 16'h4000, 16'h4000, 16'h4400);
        req_valid = 4'b1111;
        repeat (8) step();
        req_valid = '0;
        repeat (8) step();

        // back-to-back from different requesters
        set_req(1, 16'h3E00, 16'h3E00, 16'h4080);
        req_valid = 4'b0010;
        step();
        set_req(3, 16'h4200, 16'h4000, 16'h4600);
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        repeat (8) step();

        // enable drop with three ops in flight
        req_valid = 4'b1111;
        repeat (3) step();
        en = 1'b0;
        #1;
        check("en_drop_ready", 32'(req_ready), 32'd0);
        check("en_drop_inflight", 32'(inflight), 32'd3);
        repeat (5) step();
        req_valid = '0;
        repeat (3) step();
        en = 1'b1;
        step();

        // asynchronous reset with ops in flight
        req_valid = 4'b1111;
        repeat (3) step();
        reset = 1'b1;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_inflight", 32'(inflight), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_mul_a", 32'(mul_a), 32'd0);
        repeat (2) step();
        reset = 1'b0;
        #1;
        check("rst_first_grant", 32'(req_ready), 32'b0001);
        step();
        req_valid = '0;
        repeat (8) step();

        // sparse requests from requester 2, then 0 and 3 compete
        for (int r = 0; r < 4; r++) begin
            set_req(2, 16'h4200, 16'h4000, 16'h4600);
            req_valid = 4'b0100;
            step();
            req_valid = '0;
            step();
        end
        set_req(0, 16'h3C00, 16'h4000, 16'h4000);
        set_req(3, 16'h4000, 16'h4000, 16'h4400);
        req_valid = 4'b1001;
        step();
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        repeat (8) step();

        // random traffic; operands held until accepted
        for (int c = 0; c < 600; c++) begin
            en = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < N_REQ; i++) begin
                if (!req_valid[i] || accepted[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    ra = rnd_fp();
                    rb = rnd_fp();
                    set_req(i, ra, rb, fpmul(ra, rb));
                end
            end
            step();
        end
        req_valid = '0;
        en = 1'b0;
        repeat (10) step();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fp_mul_sched.md
Name: fp_mul_sched

Overview:
- Round-robin scheduler that shares one pipelined fp_mul instance (fixed latency MUL_LAT) among N_REQ requesters.
- Accepts at most one multiply per cycle and drives the multiplier operands.
- Tracks the requester ID of each in-flight operation in a tag shift pipeline aligned to the multiplier latency.
- Returns each result to its originating requester as a registered one-cycle pulse.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- I_EXP, 5, exponent width passed to fp_mul
- I_MNT, 10, mantissa width passed to fp_mul
- I_DATA, I_EXP+I_MNT+1, operand/result width
- MUL_LAT, 3, cycles from operand presentation to valid fp_mul odata
- ID_W, $clog2(N_REQ), requester tag width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  scheduler enable; low blocks new grants, in-flight ops drain
- req_valid  in  N_REQ  per-requester operation request
- req_ready  out  N_REQ  one-hot grant, combinational
- req_a  in  N_REQ*I_DATA  operand A, requester i at [i*I_DATA +: I_DATA]
- req_b  in  N_REQ*I_DATA  operand B, same packing
- mul_a  out  I_DATA  to fp_mul idataA
- mul_b  out  I_DATA  to fp_mul idataB
- mul_result  in  I_DATA  from fp_mul odata
- rsp_valid  out  N_REQ  one-hot result pulse
- rsp_data  out  I_DATA  result, valid when any rsp_valid bit is set
- inflight  out  $clog2(MUL_LAT+2)  number of accepted ops not yet returned
- idle  out  1  high when inflight==0 and no req_ready asserted

Behaviour:
- Reset (async assert, sync release): rr_ptr=0; tag pipeline valid bits=0; rsp_valid=0; rsp_data=0; inflight=0; idle=1.
- While reset is high, req_ready=0 and mul_a=mul_b=0.
- Arbitration:
  - Each cycle with en=1, grant the first i with req_valid[i]=1, searching from rr_ptr upward modulo N_REQ.
  - req_ready has exactly that one bit set. req_ready=0 when en=0 or no requests.
  - req_ready never depends on req_a or req_b.
- Handshake: an op is accepted in cycle t when req_valid[i] & req_ready[i] are both high. The requester holds its operands stable while valid is high and not ready.
- Pointer update: on an accept from requester g, rr_ptr <= (g+1) mod N_REQ at the clock edge. With no accept, rr_ptr holds.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,N_REQ-1,0,...
- Operand drive:
  - mul_a/mul_b = combinational mux of the granted requester's operands.
  - Both are 0 when there is no grant. fp_mul treats exponent 0 as zero, and the result is discarded anyway.
- Tag pipeline:
  - MUL_LAT+1 stage shift register of {valid, id}.
  - Stage 0 is loaded with {accept, g} at the end of cycle t.
  - At stage MUL_LAT-1 (cycle t+MUL_LAT), the tag aligns with mul_result.
- Response:
  - At the end of cycle t+MUL_LAT, if that stage's tag is valid: rsp_data <= mul_result and rsp_valid <= onehot(id). Otherwise rsp_valid <= 0 and rsp_data holds.
  - rsp_valid is high for exactly cycle t+MUL_LAT+1. Total latency = MUL_LAT+1 = 4 cycles.
- Responses cannot be backpressured; requesters must sink one result per cycle.
- Throughput: one op per cycle sustained. Back-to-back accepts produce back-to-back responses, in issue order.
- Results pass through unmodified. No rounding, sign or exponent handling is done in this block.
- inflight:
  - Increments on accept and decrements on response pulse.
  - A simultaneous accept and response leaves it unchanged.
  - Maximum value is MUL_LAT+1; no overflow is possible by construction.
- en deassert mid-stream: no new grants; already-accepted ops still return at their scheduled cycles. idle rises once the last response pulse has been issued.
- Reset mid-operation: all in-flight tags are cleared and no responses are issued for them. fp_mul is reset from the same source.
- Same requester: it may be granted again immediately only if no other requester is valid.

Test Plan:
- Single op: after reset, req 0 issues 0x3C00*0x4000 (1.0*2.0) at cycle 5 -> req_ready[0]=1 in cycle 5; rsp_valid=4'b0001 and rsp_data=0x4000 in cycle 9; inflight 1 during cycles 6..9, then 0.
- Round-robin: all four requesters valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3. Each requester receives two pulses, 4 cycles after each of its grants, with correct data: req2 0x4200*0x4000 returns 0x4600.
- Back-to-back mixed: req1 0x3E00*0x3E00, then req3 0x4200*0x4000 on the next cycle -> rsp 0x4080 to req1, then 0x4600 to req3 on consecutive cycles.
- Enable drop: en falls with 3 ops in flight -> req_ready=0 immediately; three responses are still delivered; idle=1 the cycle after the last pulse.
- Reset mid-flight: assert reset asynchronously with inflight=3 -> rsp_valid=0, inflight=0, idle=1 at once. No stale responses appear after release. The first post-reset grant goes to requester 0.
- Sparse requests: only req2 valid every other cycle -> each gets ready in its valid cycle; rr_ptr moves to 3 after each accept; latency is exactly 4 cycles each time.
